dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder.
// A request is accepted in IDLE and held for LATENCY cycles. The access is then
// performed, and the response is held in RESP until the initiator takes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, access, err;
  logic [AW-1:0] idx;

  // Reset masks ready so that a request presented during reset is never taken.
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  // The access happens on the edge that leaves WAIT.
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign err       = (addr_q[1:0] != 2'b00) ||
                     ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign idx       = addr_q[AW+1:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: accept -> count down -> respond -> handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0)  state_nxt = RESP;
      RESP:    if (rsp_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Latency down-counter, loaded at acceptance
  always_ff @(posedge clk) begin
    if (reset)                          cnt <= 4'd0;
    else if (accept)                    cnt <= 4'(LATENCY - 1);
    else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
  end

  // Request capture. The contents are only used after a fresh acceptance, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Response registers: set at the access, hold through RESP, drop on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (!wr_q && !err) ? mem[idx] : 32'd0;
      rsp_err   <= err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Byte-lane store commit. Memory has no reset, so a reset in WAIT simply skips the commit.
  always_ff @(posedge clk) begin
    if (!reset && access && wr_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random traffic against a word-array memory model.
// The main instance uses LATENCY=2. A second instance with LATENCY=1 runs back-to-back traffic.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int NW    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        l1_req_valid, l1_req_ready, l1_req_write, l1_rsp_valid, l1_rsp_ready, l1_rsp_err;
  logic [31:0] l1_req_addr, l1_req_wdata, l1_rsp_rdata;
  logic [3:0]  l1_req_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_be(l1_req_be),
    .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl  [DEPTH];
  logic [31:0] mdl1 [DEPTH];
  logic [32:0] exp_q [$];
  logic [32:0] l1_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory reference model: the error rule, byte-lane stores and whole-word loads
  task automatic model(input bit use1, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic e);
    int w;
    w  = int'(a >> 2);
    e  = (a % 4 != 0) || ((a >> 2) >= 32'(DEPTH));
    rd = 32'd0;
    if (!e) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) begin
            if (use1) mdl1[w][8*b +: 8] = wd[8*b +: 8];
            else      mdl[w][8*b +: 8]  = wd[8*b +: 8];
          end
      end else begin
        rd = use1 ? mdl1[w] : mdl[w];
      end
    end
  endtask

  task automatic scramble();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    rsp_ready = 1'($urandom);
  endtask

  // One full transaction on the LATENCY=2 instance, with `hold` stall cycles in RESP
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold);
    logic [31:0] erd, rd0;
    logic        ee, e0;
    int          n;
    model(1'b0, wr, a, wd, be, erd, ee);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_rdy", 32'(req_ready), 32'd1);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      chk("wait_rdy", 32'(req_ready), 32'd0);
      scramble();
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(LAT));
    rd0 = rsp_rdata; e0 = rsp_err;
    chk("rdata", rd0, erd);
    chk("err", 32'(e0), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      @(negedge clk);
      chk("hold_vld", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd0);
      chk("hold_err", 32'(rsp_err), 32'(e0));
      chk("hold_rdy", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("hs_vld", 32'(rsp_valid), 32'd0);
    chk("hs_rdy", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  // LATENCY=1 response checker: rsp_ready is tied high, so each valid cycle is one response
  always @(negedge clk) begin
    if (l1_rsp_valid) begin
      if (exp_q.size() == 0) chk("l1_extra_rsp", 32'(l1_rsp_valid), 32'd0);
      else begin
        l1_e = exp_q.pop_front();
        chk("l1_rdata", l1_rsp_rdata, l1_e[31:0]);
        chk("l1_err", 32'(l1_rsp_err), 32'(l1_e[32]));
      end
    end
  end

  initial begin
    logic [31:0] erd, a, wd;
    logic        ee, wr;
    logic [3:0]  be;
    int          n, r;
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    l1_req_valid = 0; l1_req_write = 0; l1_req_addr = 0; l1_req_wdata = 0; l1_req_be = 0;
    l1_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1 chk("rst_rel_rdy", 32'(req_ready), 32'd1);

    // Give every word that the traffic touches a known value
    for (int w = 0; w < NW; w++) txn(1'b1, 32'(4*w), $urandom, 4'hF, 0);
    txn(1'b1, 32'(4*(DEPTH-1)), $urandom, 4'hF, 0);

    // Directed cases
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
    txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h12, 32'h0, 4'hF, 0);
    txn(1'b0, 32'(4*DEPTH), 32'h0, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
    txn(1'b1, 32'h11, 32'h55555555, 4'hF, 0);
    txn(1'b1, 32'(4*DEPTH), 32'h55555555, 4'hF, 0);
    txn(1'b1, 32'h10, 32'h66666666, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5);

    // Reset during WAIT abandons the store
    @(negedge clk);
    chk("rw_rdy", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rw_vld", 32'(rsp_valid), 32'd0);
      chk("rw_rdy0", 32'(req_ready), 32'd0);
    end
    reset = 1'b0;
    #1 chk("rw_rel_rdy", 32'(req_ready), 32'd1);
    repeat (3) begin @(negedge clk); chk("rw_idle_vld", 32'(rsp_valid), 32'd0); end
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0);

    // Reset during RESP drops the response
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h8; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("rr_vld", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_drop_vld", 32'(rsp_valid), 32'd0);
    chk("rr_drop_rdata", rsp_rdata, 32'd0);
    // Reset wins over a simultaneous request
    req_valid = 1; req_write = 1; req_addr = 32'h4; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 0; reset = 1'b0;
    repeat (4) begin @(negedge clk); chk("rp_vld", 32'(rsp_valid), 32'd0); end
    txn(1'b0, 32'h4, 32'h0, 4'hF, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'(4 * $urandom_range(0, NW-1));
      else if (r == 7) a = 32'(4 * $urandom_range(0, NW-1) + $urandom_range(1, 3));
      else if (r == 8) a = $urandom_range(0, 1) ? 32'(4*(DEPTH-1)) : 32'(4*DEPTH + 4*$urandom_range(0, 3));
      else             a = $urandom | 32'h8000_0000;
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    // LATENCY=1 back-to-back traffic with rsp_ready tied high
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k < 4) begin
        wr = 1'b1; a = 32'(4*k); wd = $urandom; be = 4'hF;
      end else begin
        wr = 1'($urandom);
        a  = 32'(4 * $urandom_range(0, 3) + (($urandom_range(0, 7) == 0) ? 1 : 0));
        wd = $urandom; be = 4'($urandom);
      end
      l1_req_valid = 1; l1_req_write = wr; l1_req_addr = a; l1_req_wdata = wd; l1_req_be = be;
      model(1'b1, wr, a, wd, be, erd, ee);
      exp_q.push_back({ee, erd});
      chk("l1_rdy", 32'(l1_req_ready), 32'd1);
      @(posedge clk);
      n = 0;
      do begin @(negedge clk); n++; end while (!l1_req_ready && n < 10);
      chk("l1_gap", 32'(n), 32'd3);
    end
    l1_req_valid = 0;
    repeat (4) @(negedge clk);
    chk("l1_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
